tick_timer_gen: RTL and testbench
=================================

TICK_TIMER_GEN -- requirements
Module: tick_timer_gen

Interface
REQ-001 Parameter WIDTH, default 26, width of the cycle counter and period register.
REQ-002 Parameter DEFAULT_PERIOD, default 50_000_000, period in clk cycles after reset; SHALL be >=1 and fit in WIDTH bits.
REQ-003 Parameter TICK_W, default 6, width of the tick counter.
REQ-004 Parameter TICK_MOD, default 60, tick counter modulus; SHALL be 1..2^TICK_W.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  run request; low pauses counting without clearing.
REQ-008 clear  input  1  synchronous soft clear to IDLE.
REQ-009 mode  input  1  0 = periodic, 1 = one-shot.
REQ-010 load  input  1  one-cycle strobe to write load_period.
REQ-011 load_period  input  WIDTH  new period in cycles.
REQ-012 clk_cnt  output  WIDTH  current cycle count, range 0..period-1.
REQ-013 tick  output  1  one-cycle pulse on each period wrap.
REQ-014 tick_cnt  output  TICK_W  ticks modulo TICK_MOD.
REQ-015 busy  output  1  high in RUN or PAUSE.
REQ-016 done  output  1  high in DONE (one-shot expired).

Function
REQ-017 States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
REQ-018 Priority per edge: reset > clear > load > enable/count.
REQ-019 IDLE, enable=1: go to RUN with clk_cnt held at 0 on that edge.
REQ-020 RUN, enable=1: clk_cnt increments by 1; at period-1 it wraps to 0 and tick asserts on the same edge.
REQ-021 A tick SHALL occur exactly every period cycles; period P yields tick high for one cycle, P edges after the edge that sampled enable in IDLE.
REQ-022 Period 1: clk_cnt stays 0 and tick is high every RUN cycle.
REQ-023 RUN, enable=0: go to PAUSE; clk_cnt and tick_cnt hold; no tick.
REQ-024 PAUSE, enable=1: return to RUN; counting resumes from the held value on the next edge.
REQ-025 RUN wrap with mode=1: go to DONE; tick pulses once; clk_cnt=0; done=1.
REQ-026 RUN wrap with mode=0: stay in RUN.
REQ-027 mode is sampled at each wrap; a change mid-period is legal.
REQ-028 DONE: holds regardless of enable; leaves only on clear or load.
REQ-029 tick_cnt increments on each tick; wraps from TICK_MOD-1 to 0; TICK_MOD=1 holds 0.
REQ-030 load with load_period>=1: period_r takes the new value, clk_cnt goes to 0, tick is suppressed that edge.
REQ-031 After a valid load: RUN/PAUSE keep their state; DONE goes to IDLE; tick_cnt is unchanged.
REQ-032 load with load_period=0: ignored entirely, including clk_cnt and state.
REQ-033 clear: state IDLE, clk_cnt=0, tick_cnt=0, tick=0; period_r kept.
REQ-034 clear and load in the same cycle: clear applies and period_r still updates if load_period>=1.

Reset
REQ-035 reset sets state=IDLE, clk_cnt=0, tick_cnt=0, tick=0, busy=0, done=0, period_r=DEFAULT_PERIOD.
REQ-036 reset asserted mid-RUN SHALL abort the period with no tick, and the block SHALL restart from IDLE.

Structure
REQ-037 Package tick_timer_pkg SHALL hold the state enum typedef and the MODE_PERIODIC/MODE_ONESHOT constants.
REQ-038 One sub-module, mod_counter (parametrised width/modulus, inc, clr, wrap output), SHALL implement tick_cnt.
REQ-039 Width comparisons SHALL be done at WIDTH bits with no truncation of period_r-1.

Verification
REQ-040 DEFAULT_PERIOD=4, mode=0, enable held from edge 0 -> tick high after edges 4, 8, 12; clk_cnt sequence 0,0,1,2,3,0.
REQ-041 P=4, enable low for 3 cycles at clk_cnt=2 -> clk_cnt holds 2, busy=1, and the next tick is delayed exactly 3 cycles.
REQ-042 mode=1, load_period=5 -> a single tick 5 edges after start, done=1, and no further ticks with enable held high.
REQ-043 TICK_MOD=3, P=1 -> tick_cnt sequence 1,2,0,1; load_period=0 mid-run -> no change.
REQ-044 Simultaneous clear+load(7) mid-RUN -> IDLE, counters 0, and the next run ticks every 7 cycles.
REQ-045 reset pulse at clk_cnt=P-1 -> no tick, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap_c flags the increment that rolls over.
module mod_counter #(
  parameter int unsigned W   = 6,
  parameter int unsigned MOD = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_next;

  assign wrap_c = inc && (count == LAST);

  // Next count: clear wins, otherwise step and roll over at MOD-1.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = (count == LAST) ? '0 : count + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/tick_timer_gen.sv
// Programmable-period tick generator with pause, one-shot mode and tick counter.
module tick_timer_gen
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter int unsigned TICK_W         = 6,
  parameter int unsigned TICK_MOD       = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_period,
  output logic [WIDTH-1:0]  clk_cnt,
  output logic              tick,
  output logic [TICK_W-1:0] tick_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] PERIOD_INIT = WIDTH'(DEFAULT_PERIOD);

  state_e           state, state_next;
  logic [WIDTH-1:0] period_r, period_next;
  logic [WIDTH-1:0] cnt_next;
  logic             tick_next, busy_next, done_next;
  logic             load_ok_c, last_c, inc_c, clr_c;
  logic             unused_tick_wrap_c;

  // A zero period is meaningless, so such loads are dropped.
  assign load_ok_c = load && (load_period != '0);
  // period_r is never 0, so period_r-1 cannot underflow.
  assign last_c    = (clk_cnt == (period_r - WIDTH'(1)));

  // Next-state and output decode; priority clear > load > enable.
  always_comb begin
    state_next  = state;
    period_next = period_r;
    cnt_next    = clk_cnt;
    tick_next   = 1'b0;
    inc_c       = 1'b0;
    clr_c       = 1'b0;

    if (load_ok_c) begin
      period_next = load_period;
    end

    if (clear) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      clr_c      = 1'b1;
    end else if (load_ok_c) begin
      cnt_next = '0;
      if (state == ST_DONE) begin
        state_next = ST_IDLE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_next = '0;
          if (enable) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (enable) begin
            state_next = ST_RUN;
            if (last_c) begin
              cnt_next  = '0;
              tick_next = 1'b1;
              inc_c     = 1'b1;
              if (mode == MODE_ONESHOT) begin
                state_next = ST_DONE;
              end
            end else begin
              cnt_next = clk_cnt + WIDTH'(1);
            end
          end else begin
            state_next = ST_PAUSE;
          end
        end
        ST_DONE: begin
          cnt_next = '0;
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    busy_next = (state_next == ST_RUN) || (state_next == ST_PAUSE);
    done_next = (state_next == ST_DONE);
  end

  // State, period and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      period_r <= PERIOD_INIT;
      clk_cnt  <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      period_r <= period_next;
      clk_cnt  <= cnt_next;
      tick     <= tick_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Tick counter advances once per emitted tick.
  mod_counter #(
    .W   (TICK_W),
    .MOD (TICK_MOD)
  ) u_tick_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (inc_c),
    .clr    (clr_c),
    .count  (tick_cnt),
    .wrap_c (unused_tick_wrap_c)
  );

endmodule

// File: tb/tb_tick_timer_gen.sv
// Directed, table-driven bench for tick_timer_gen (P=4, TICK_MOD=3).
module tb_tick_timer_gen;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned TICK_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              mode = 1'b0;
  logic              load = 1'b0;
  logic [WIDTH-1:0]  load_period = '0;
  logic [WIDTH-1:0]  clk_cnt;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             rst;
    logic             en;
    logic             clr;
    logic             md;
    logic             ld;
    logic [WIDTH-1:0] lp;
    int               e_cnt;
    int               e_tick;
    int               e_tc;
    int               e_busy;
    int               e_done;
  } vec_t;

  vec_t vecs[$];

  tick_timer_gen #(
    .WIDTH          (WIDTH),
    .DEFAULT_PERIOD (4),
    .TICK_W         (TICK_W),
    .TICK_MOD       (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .mode        (mode),
    .load        (load),
    .load_period (load_period),
    .clk_cnt     (clk_cnt),
    .tick        (tick),
    .tick_cnt    (tick_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int t, input int tc,
                           input int b, input int d);
    check({tag, ".clk_cnt"}, int'(clk_cnt), c);
    check({tag, ".tick"}, int'(tick), t);
    check({tag, ".tick_cnt"}, int'(tick_cnt), tc);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".done"}, int'(done), d);
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic m,
                      input logic l, input logic [WIDTH-1:0] lp);
    reset = r; enable = e; clear = c; mode = m; load = l; load_period = lp;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic e, input logic c, input logic m,
                              input logic l, input int lp, input int ec, input int et,
                              input int etc, input int eb, input int ed);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.md = m; v.ld = l; v.lp = WIDTH'(lp);
    v.e_cnt = ec; v.e_tick = et; v.e_tc = etc; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    // reset state
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // periodic P=4 from reset: ticks 4, 8, 12 edges after start
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,  2, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,  3, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  1, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  2, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  3, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    // pause 3 cycles at clk_cnt=2: tick moves 3 edges later
    add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    // clear mid-run
    add(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // load 5 in IDLE beats enable; then one-shot
    add(0, 1, 0, 1, 1, 5,  0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,  2, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,  3, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,  4, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,  0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0,  0, 0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0,  0, 0, 1, 0, 1);
    // load in DONE returns to IDLE, tick_cnt kept
    add(0, 1, 0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // P=1: tick every RUN cycle, tick_cnt 1,2,0,1
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    // load_period=0 ignored: counting continues
    add(0, 1, 0, 0, 1, 0,  0, 1, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    // load 4 mid-run: stays RUN, clk_cnt 0, no tick
    add(0, 1, 0, 0, 1, 4,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  2, 0, 0, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].md, vecs[i].ld, vecs[i].lp);
      check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tick, vecs[i].e_tc,
                vecs[i].e_busy, vecs[i].e_done);
    end

    // clear + load(7) together mid-run
    step(0, 1, 1, 0, 1, 8'd7);
    check_all("clrld", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'd0);
    check_all("p7_start", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 27; k++) begin
      step(0, 1, 0, 0, 0, 8'd0);
      check_all($sformatf("p7_k%0d", k), k % 7, (k % 7 == 0) ? 1 : 0, (k / 7) % 3, 1, 0);
    end

    // reset at clk_cnt=P-1: no tick, reset values, period back to 4
    step(1, 1, 0, 0, 0, 8'd0);
    check_all("rst_mid", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'd0);
    check_all("p4_start", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, 0, 0, 8'd0);
      check_all($sformatf("p4_k%0d", k), k % 4, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
